// File: rtl/jt12_wr_pkg.sv
// jt12_wr_pkg: shared types and parameter defaults for the FM register-write scheduler
package jt12_wr_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int ADDR_GAP_DEF = 2;
  localparam int TIMEOUT_DEF = 255;
  typedef enum logic [2:0] {IDLE, ADR, GAP, DAT, BSY} state_t;
  typedef struct packed {
    logic       part;
    logic [7:0] regn;
    logic [7:0] val;
  } entry_t;
endpackage

// File: rtl/jt12_wr_fifo.sv
// jt12_wr_fifo: synchronous write queue with registered ready (not full)
module jt12_wr_fifo import jt12_wr_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [16:0]            din,
  output logic [16:0]            dout,
  output logic                   full,
  output logic                   empty,
  output logic                   ready,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [16:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic ready_q, ready_d;
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    ready_d = level_d != (AW+1)'(DEPTH);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      ready_q <= ready_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  assign dout = mem_q[rd_q];
  assign full = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign ready = ready_q;
  assign level = level_q;
endmodule

// File: rtl/jt12_wr_sched.sv
// jt12_wr_sched: queues host register writes and replays them to the FM core
// as address strobe, gap, data strobe and busy poll, all paced by cen.
module jt12_wr_sched import jt12_wr_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_GAP = ADDR_GAP_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_part,
  input  logic [7:0]             req_reg,
  input  logic [7:0]             req_val,
  output logic [1:0]             ym_addr,
  output logic [7:0]             ym_din,
  output logic                   ym_cs_n,
  output logic                   ym_wr_n,
  input  logic [7:0]             ym_dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle,
  output logic                   timeout_err,
  input  logic                   err_clr
);
  localparam int CW = $clog2(TIMEOUT + ADDR_GAP + 1);
  state_t state_q, state_d;
  entry_t hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic err_q, err_d, cs_q, cs_d, wr_q, wr_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic [16:0] head;
  logic push, pop, full, empty;
  logic unused_dout;
  assign unused_dout = ^ym_dout[6:0];
  assign push = req_valid && req_ready && !full;
  assign pop = cen && state_q == IDLE && !empty;
  jt12_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .din({req_part, req_reg, req_val}), .dout(head),
    .full(full), .empty(empty), .ready(req_ready), .level(level)
  );
  assign cnt_inc = cnt_q + CW'(1);
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    cnt_d = cnt_q;
    err_d = err_clr ? 1'b0 : err_q;
    if (cen) begin
      unique case (state_q)
        IDLE: if (!empty) begin
          state_d = ADR;
          hold_d = entry_t'(head);
        end
        ADR: begin
          state_d = GAP;
          cnt_d = '0;
        end
        GAP: begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(ADDR_GAP)) state_d = DAT;
        end
        DAT: begin
          state_d = BSY;
          cnt_d = '0;
        end
        BSY: begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CW'(2) && !ym_dout[7]) state_d = IDLE;
          else if (cnt_inc == CW'(TIMEOUT)) begin
            state_d = IDLE;
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // outputs are decoded from the next state so every pin is a plain flop
    cs_d = !(state_d inside {ADR, DAT, BSY});
    wr_d = !(state_d inside {ADR, DAT});
    addr_d = state_d == IDLE ? 2'b00 : {hold_d.part, state_d == DAT};
    din_d = state_d == IDLE ? 8'h00 : (state_d inside {ADR, GAP}) ? hold_d.regn : hold_d.val;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      cs_q <= 1'b1;
      wr_q <= 1'b1;
      addr_q <= 2'b00;
      din_q <= 8'h00;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      cs_q <= cs_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      din_q <= din_d;
    end
  end
  assign ym_cs_n = cs_q;
  assign ym_wr_n = wr_q;
  assign ym_addr = addr_q;
  assign ym_din = din_q;
  assign timeout_err = err_q;
  assign idle = empty && state_q == IDLE;
endmodule
